// File: rtl/saxil_to_dev.sv
// AXI-Lite slave to Ibex-style device port bridge (req/gnt, rvalid completion).
// Ports: S_AXI_* AXI-Lite slave channels; data_* device request/response port.
module saxil_to_dev #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [31:0]               S_AXI_WDATA,
  input  logic [3:0]                S_AXI_WSTRB,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  output logic [31:0]               S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY,
  output logic                      data_req_o,
  output logic [31:0]               data_addr_o,
  output logic                      data_we_o,
  output logic [3:0]                data_be_o,
  output logic [31:0]               data_wdata_o,
  input  logic                      data_gnt_i,
  input  logic                      data_rvalid_i,
  input  logic                      data_err_i,
  input  logic [31:0]               data_rdata_i
);

  if (AXI_DATA_WIDTH != 32) begin : g_bad_dw
    $error("saxil_to_dev: AXI_DATA_WIDTH must be 32");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_B, S_R
  } state_t;

  state_t      r_state;
  logic        r_is_wr;
  logic        r_prio_wr;
  logic        r_aw_full;
  logic        r_w_full;
  logic        r_ar_full;
  logic [31:0] r_aw_addr;
  logic [31:0] r_ar_addr;
  logic [31:0] r_w_data;
  logic [3:0]  r_w_strb;

  logic [31:0] w_aw_ext;
  logic [31:0] w_ar_ext;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_ar_hs;
  logic [31:0] w_aw_sel;
  logic [31:0] w_ar_sel;
  logic [31:0] w_wd_sel;
  logic [3:0]  w_ws_sel;
  logic        w_wr_rdy;
  logic        w_rd_rdy;
  logic        w_pick_wr;
  logic        w_gnt;

  assign w_aw_ext = 32'(S_AXI_AWADDR);
  assign w_ar_ext = 32'(S_AXI_ARADDR);

  assign S_AXI_AWREADY = !rst && !r_aw_full;
  assign S_AXI_WREADY  = !rst && !r_w_full;
  assign S_AXI_ARREADY = !rst && !r_ar_full;

  assign w_aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign w_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Idle looks through the holding registers at same-cycle
  // handshakes so a request can issue the cycle after capture.
  assign w_aw_sel = r_aw_full ? r_aw_addr : w_aw_ext;
  assign w_ar_sel = r_ar_full ? r_ar_addr : w_ar_ext;
  assign w_wd_sel = r_w_full ? r_w_data : S_AXI_WDATA;
  assign w_ws_sel = r_w_full ? r_w_strb : S_AXI_WSTRB;

  assign w_wr_rdy = (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs);
  assign w_rd_rdy = r_ar_full || w_ar_hs;
  assign w_pick_wr = w_wr_rdy && (!w_rd_rdy || r_prio_wr);

  assign w_gnt = (r_state == S_REQ) && data_gnt_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_ar_full <= 1'b0;
      r_aw_addr <= '0;
      r_ar_addr <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= w_aw_ext;
      end else if (w_gnt && r_is_wr) begin
        r_aw_full <= 1'b0;
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= S_AXI_WDATA;
        r_w_strb <= S_AXI_WSTRB;
      end else if (w_gnt && r_is_wr) begin
        r_w_full <= 1'b0;
      end
      if (w_ar_hs) begin
        r_ar_full <= 1'b1;
        r_ar_addr <= w_ar_ext;
      end else if (w_gnt && !r_is_wr) begin
        r_ar_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_is_wr      <= 1'b0;
      r_prio_wr    <= 1'b0;
      data_req_o   <= 1'b0;
      data_addr_o  <= '0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_wdata_o <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= '0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RRESP  <= '0;
      S_AXI_RDATA  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr_rdy || w_rd_rdy) begin
            r_is_wr      <= w_pick_wr;
            data_req_o   <= 1'b1;
            data_we_o    <= w_pick_wr;
            data_addr_o  <= (w_pick_wr ? w_aw_sel : w_ar_sel)
                            & 32'hFFFF_FFFC;
            data_be_o    <= w_pick_wr ? w_ws_sel : 4'hF;
            data_wdata_o <= w_pick_wr ? w_wd_sel : 32'h0;
            r_state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (data_gnt_i) begin
            data_req_o <= 1'b0;
            r_prio_wr  <= !r_is_wr;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (data_rvalid_i) begin
            if (r_is_wr) begin
              S_AXI_BRESP  <= data_err_i ? 2'b10 : 2'b00;
              S_AXI_BVALID <= 1'b1;
              r_state      <= S_B;
            end else begin
              S_AXI_RRESP  <= data_err_i ? 2'b10 : 2'b00;
              S_AXI_RDATA  <= data_rdata_i;
              S_AXI_RVALID <= 1'b1;
              r_state      <= S_R;
            end
          end
        end
        S_B: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        S_R: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_saxil_to_dev.sv
// Directed self-checking bench for saxil_to_dev.
// Drives AXI-Lite channels and plays the device side by hand.
module tb_saxil_to_dev;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, araddr, wdata, rdata, d_addr, d_wdata, d_rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb, d_be;
  logic [1:0]  bresp, rresp;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;

  int total = 0;
  int bad = 0;
  int n;

  saxil_to_dev dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .data_req_o(d_req), .data_addr_o(d_addr),
    .data_we_o(d_we), .data_be_o(d_be),
    .data_wdata_o(d_wdata), .data_gnt_i(d_gnt),
    .data_rvalid_i(d_rvalid), .data_err_i(d_err),
    .data_rdata_i(d_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for a request, check it, grant after gdly cycles,
  // complete it, hold the response for hold cycles, accept it.
  task automatic dev_txn(input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd,
                         input logic err, input logic [31:0] rd,
                         input int gdly, input int hold,
                         output int waited);
    int k = 0;
    while (d_req !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    waited = k;
    chk("req_seen", d_req, 1);
    chk("we", d_we, we);
    chk("addr", d_addr, addr);
    if (we) begin
      chk("be", d_be, be);
      chk("wdata", d_wdata, wd);
    end
    for (int i = 0; i < gdly; i++) begin
      tick();
      chk("req_hold", d_req, 1);
      chk("addr_hold", d_addr, addr);
    end
    d_gnt = 1'b1;
    tick();
    d_gnt = 1'b0;
    chk("req_drop", d_req, 0);
    d_rvalid = 1'b1;
    d_err = err;
    d_rdata = rd;
    tick();
    d_rvalid = 1'b0;
    d_err = 1'b0;
    d_rdata = '0;
    for (int i = 0; i <= hold; i++) begin
      if (we) begin
        chk("bvalid", bvalid, 1);
        chk("bresp", bresp, err ? 2'b10 : 2'b00);
      end else begin
        chk("rvalid", rvalid, 1);
        chk("rresp", rresp, err ? 2'b10 : 2'b00);
        chk("rdata", rdata, rd);
      end
      chk("no_req_busy", d_req, 0);
      if (i < hold) tick();
    end
    if (we) bready = 1'b1;
    else rready = 1'b1;
    tick();
    bready = 1'b0;
    rready = 1'b0;
    chk("resp_drop", we ? bvalid : rvalid, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_req", d_req, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    rst = 1'b0;
    #1;
    chk("rel_awready", awready, 1);
    chk("rel_wready", wready, 1);
    chk("rel_arready", arready, 1);
  endtask

  initial begin
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 0; araddr = '0; arvalid = 0; rready = 0;
    d_gnt = 0; d_rvalid = 0; d_err = 0; d_rdata = '0;
    do_reset();
    chk("rst_addr", d_addr, 0);
    chk("rst_rdata", rdata, 0);

    // single write, AW and W together, immediate gnt
    awaddr = 32'h100; awvalid = 1;
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    chk("wr_awready_full", awready, 0);
    dev_txn(1, 32'h100, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, n);
    chk("wr_latency", n, 0);

    // single read, gnt delayed 3 cycles
    araddr = 32'h204; arvalid = 1;
    tick();
    arvalid = 0;
    dev_txn(0, 32'h204, 4'h0, 0, 0, 32'h12345678, 3, 0, n);
    chk("rd_latency", n, 0);

    // W two cycles before AW, unaligned AW address
    wdata = 32'hA5A5A5A5; wstrb = 4'h3; wvalid = 1;
    tick();
    wvalid = 0;
    chk("wfirst_wready", wready, 0);
    chk("wfirst_noreq0", d_req, 0);
    tick();
    chk("wfirst_noreq1", d_req, 0);
    awaddr = 32'h302; awvalid = 1;
    tick();
    awvalid = 0;
    chk("wfirst_wready_req", wready, 0);
    dev_txn(1, 32'h300, 4'h3, 32'hA5A5A5A5, 0, 0, 0, 0, n);
    chk("wfirst_wready_after", wready, 1);

    // tie after reset: read first, then alternate
    do_reset();
    araddr = 32'h40; arvalid = 1;
    awaddr = 32'h80; awvalid = 1;
    wdata = 32'h55; wstrb = 4'hF; wvalid = 1;
    for (int p = 0; p < 4; p++) begin
      dev_txn(0, 32'h40, 4'h0, 0, 0, 32'h1000 + p, 0, 0, n);
      dev_txn(1, 32'h80, 4'hF, 32'h55, 0, 0, 0, 0, n);
    end
    arvalid = 0; awvalid = 0; wvalid = 0;
    do_reset();

    // device error on write, B stall, queued read behind it
    awaddr = 32'h8; awvalid = 1;
    wdata = 32'h77; wstrb = 4'h0; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    araddr = 32'h13; arvalid = 1;
    tick();
    arvalid = 0;
    chk("err_ar_captured", arready, 0);
    dev_txn(1, 32'h8, 4'h0, 32'h77, 1, 0, 0, 5, n);
    dev_txn(0, 32'h10, 4'h0, 0, 1, 32'hCAFEF00D, 0, 0, n);

    // reset while waiting for completion
    araddr = 32'h20; arvalid = 1;
    tick();
    arvalid = 0;
    chk("mid_req", d_req, 1);
    d_gnt = 1;
    tick();
    d_gnt = 0;
    rst = 1;
    #1;
    chk("mid_arready", arready, 0);
    chk("mid_awready", awready, 0);
    chk("mid_rvalid", rvalid, 0);
    tick();
    rst = 0;
    #1;
    chk("post_awready", awready, 1);
    chk("post_wready", wready, 1);
    chk("post_arready", arready, 1);
    d_rvalid = 1; d_rdata = 32'hBAD0BAD0;
    tick();
    d_rvalid = 0; d_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rvalid", rvalid, 0);
      chk("post_bvalid", bvalid, 0);
      chk("post_req", d_req, 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
